// File: rtl/item_pkg.sv
// Shared tables, types and helpers for the multi-bubble collectible manager.
// Platform geometry, bubble kinds and the procedural bubble texture live here.
package item_pkg;

  localparam int NUM_PLATFORMS = 7;

  localparam logic [9:0] PLAT_Y [NUM_PLATFORMS] = '{
    10'd116, 10'd116, 10'd199, 10'd282, 10'd282, 10'd365, 10'd448
  };

  localparam logic [9:0] PLAT_XMIN [NUM_PLATFORMS] = '{
    10'd16, 10'd480, 10'd80, 10'd16, 10'd384, 10'd112, 10'd16
  };

  localparam logic [9:0] PLAT_XMASK [NUM_PLATFORMS] = '{
    10'd127, 10'd127, 10'd255, 10'd127, 10'd127, 10'd255, 10'd511
  };

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_HIDDEN,
    S_SPAWN
  } slot_state_e;

  typedef struct packed {
    slot_state_e st;
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [5:0]  kind;
    logic [2:0]  plat;
  } slot_t;

  localparam logic [5:0] KIND_T1 = 6'd30;
  localparam logic [5:0] KIND_T2 = 6'd45;
  localparam logic [5:0] KIND_T3 = 6'd55;
  localparam logic [5:0] KIND_T4 = 6'd63;

  localparam logic [7:0] PTS_0 = 8'd10;
  localparam logic [7:0] PTS_1 = 8'd20;
  localparam logic [7:0] PTS_2 = 8'd30;
  localparam logic [7:0] PTS_3 = 8'd100;
  localparam logic [7:0] PTS_4 = 8'd200;

  localparam logic [11:0] KEY_COLOUR = 12'hFF0;

  localparam int JOJO_W = 25;
  localparam int JOJO_H = 60;
  localparam int HIT_W  = 17;
  localparam int HIT_H  = 13;
  localparam int TILE   = 16;

  function automatic logic [7:0] kind_points(input logic [5:0] k);
    logic [7:0] p;
    unique case (1'b1)
      (k < KIND_T1):                 p = PTS_0;
      (k >= KIND_T1 && k < KIND_T2): p = PTS_1;
      (k >= KIND_T2 && k < KIND_T3): p = PTS_2;
      (k >= KIND_T3 && k < KIND_T4): p = PTS_3;
      default:                       p = PTS_4;
    endcase
    return p;
  endfunction

  function automatic logic [6:0] kind_rowoff(input logic [5:0] k);
    logic [6:0] r;
    unique case (1'b1)
      (k < KIND_T1):                 r = 7'd0;
      (k >= KIND_T1 && k < KIND_T2): r = 7'd16;
      (k >= KIND_T2 && k < KIND_T3): r = 7'd32;
      (k >= KIND_T3 && k < KIND_T4): r = 7'd48;
      default:                       r = 7'd64;
    endcase
    return r;
  endfunction

  // Five 16x16 tiles stacked vertically; a disc per tile, key colour outside.
  function automatic logic [11:0] bubble_texel(input logic [10:0] addr);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] hue;
    int dx;
    int dy;
    r   = addr[7:4];
    c   = addr[3:0];
    hue = {1'b0, addr[10:8]} + 4'd1;
    dx  = 2 * int'(c) - 15;
    dy  = 2 * int'(r) - 15;
    if (dx * dx + dy * dy < 200)
      return {hue, r, c};
    return KEY_COLOUR;
  endfunction

endpackage

// File: rtl/ROM_Bubble_wrapper.sv
// Synchronous bubble texture ROM, 80 rows of 16 texels, one-cycle read.
// Contents come from the procedural texture in the package.
module ROM_Bubble_wrapper
  import item_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [11:0] data
);

  always_ff @(posedge clk) begin
    data <= bubble_texel(addr);
  end

endmodule

// File: rtl/bubble_slot.sv
// One bubble slot: ACTIVE/HIDDEN/SPAWN state machine, position/kind
// registers, respawn delay counter and the JOJO overlap compare.
module bubble_slot
  import item_pkg::*;
#(
  parameter int INIT_PLAT      = 0,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] jojo_x,
  input  logic [9:0] jojo_y,
  input  logic       collect,
  input  logic       spawn_go,
  input  logic [9:0] spawn_bx,
  input  logic [9:0] spawn_by,
  input  logic [5:0] spawn_kind,
  input  logic [2:0] spawn_plat,
  output slot_t      info,
  output logic       hit,
  output logic       want_spawn
);

  slot_state_e state;
  slot_state_e state_n;
  logic [9:0]  bx;
  logic [9:0]  by;
  logic [5:0]  kind;
  logic [2:0]  plat;
  logic [7:0]  cnt;
  logic        overlap;

  always_ff @(posedge clk) begin
    if (reset) state <= S_ACTIVE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_ACTIVE: if (collect) state_n = S_HIDDEN;
      S_HIDDEN: if (frame_tick && cnt == 8'd1) state_n = S_SPAWN;
      S_SPAWN:  if (spawn_go) state_n = S_ACTIVE;
      default:  state_n = S_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bx   <= PLAT_XMIN[INIT_PLAT];
      by   <= PLAT_Y[INIT_PLAT];
      kind <= '0;
      plat <= 3'(INIT_PLAT);
      cnt  <= '0;
    end else begin
      if (state == S_ACTIVE && collect)
        cnt <= 8'(RESPAWN_FRAMES);
      else if (state == S_HIDDEN && frame_tick)
        cnt <= cnt - 8'd1;
      if (state == S_SPAWN && spawn_go) begin
        bx   <= spawn_bx;
        by   <= spawn_by;
        kind <= spawn_kind;
        plat <= spawn_plat;
      end
    end
  end

  always_comb begin
    overlap = ({1'b0, bx} + 11'(HIT_W) > {1'b0, jojo_x})
           && ({1'b0, bx} < {1'b0, jojo_x} + 11'(JOJO_W))
           && ({1'b0, by} + 11'(HIT_H) > {1'b0, jojo_y})
           && ({1'b0, by} < {1'b0, jojo_y} + 11'(JOJO_H));
  end

  always_comb begin
    hit        = (state == S_ACTIVE) && overlap;
    want_spawn = (state == S_SPAWN);
    info       = '{st: state, bx: bx, by: by, kind: kind, plat: plat};
  end

endmodule

// File: rtl/item_bubble_array.sv
// Multi-bubble collectible manager: slot array, hit/spawn arbitration,
// LFSR placement, saturating score and the registered pixel path.
module item_bubble_array
  import item_pkg::*;
#(
  parameter int          NUM_BUBBLES    = 3,
  parameter int          RESPAWN_FRAMES = 30,
  parameter int          SCORE_MAX      = 9999,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [9:0]  jojo_x,
  input  logic [9:0]  jojo_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        bubble_on,
  output logic [11:0] rgb_out,
  output logic [13:0] score,
  output logic        new_score,
  output logic [7:0]  points
);

  slot_t                  info [NUM_BUBBLES];
  logic [NUM_BUBBLES-1:0] hit;
  logic [NUM_BUBBLES-1:0] want;
  logic [NUM_BUBBLES-1:0] collect;
  logic [NUM_BUBBLES-1:0] spawn_go;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [2:0]  plat_sel;
  logic [9:0]  xsum;
  logic [9:0]  spawn_bx;
  logic [9:0]  spawn_by;
  logic        blocked;
  logic        found_h;
  logic        found_s;
  logic [5:0]  gkind;
  logic [7:0]  gpts;
  logic [14:0] score_sum;

  logic        pix_hit;
  logic [10:0] pix_addr;
  logic [3:0]  pix_dx;
  logic [3:0]  pix_dy;
  logic        vis_q;
  logic [11:0] rom_q;

  for (genvar i = 0; i < NUM_BUBBLES; i++) begin : g_slot
    bubble_slot #(
      .INIT_PLAT      (i),
      .RESPAWN_FRAMES (RESPAWN_FRAMES)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .jojo_x     (jojo_x),
      .jojo_y     (jojo_y),
      .collect    (collect[i]),
      .spawn_go   (spawn_go[i]),
      .spawn_bx   (spawn_bx),
      .spawn_by   (spawn_by),
      .spawn_kind (lfsr[15:10]),
      .spawn_plat (plat_sel),
      .info       (info[i]),
      .hit        (hit[i]),
      .want_spawn (want[i])
    );
  end

  always_comb begin
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    plat_sel = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    xsum     = PLAT_XMIN[plat_sel] + (lfsr[9:0] & PLAT_XMASK[plat_sel]);
    spawn_bx = xsum & 10'h3FE;
    spawn_by = PLAT_Y[plat_sel];
  end

  // Lowest-index hitter is collected; lowest SPAWN slot tries its platform.
  always_comb begin
    collect  = '0;
    spawn_go = '0;
    gkind    = '0;
    blocked  = 1'b0;
    found_h  = 1'b0;
    found_s  = 1'b0;
    for (int i = 0; i < NUM_BUBBLES; i++) begin
      if (hit[i] && !found_h) begin
        collect[i] = 1'b1;
        gkind      = info[i].kind;
        found_h    = 1'b1;
      end
      if (want[i] && !found_s) begin
        spawn_go[i] = 1'b1;
        found_s     = 1'b1;
      end
      if (info[i].st == S_ACTIVE && info[i].plat == plat_sel)
        blocked = 1'b1;
    end
    if (blocked) spawn_go = '0;
  end

  always_comb begin
    gpts      = kind_points(gkind);
    score_sum = {1'b0, score} + 15'(gpts);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      score     <= '0;
      new_score <= 1'b0;
      points    <= '0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      new_score <= found_h;
      if (found_h) begin
        points <= gpts;
        score  <= (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX)
                                               : score_sum[13:0];
      end
    end
  end

  // Reverse scan so the lowest-index covering slot owns the pixel.
  always_comb begin
    pix_hit  = 1'b0;
    pix_addr = '0;
    pix_dx   = '0;
    pix_dy   = '0;
    for (int i = NUM_BUBBLES - 1; i >= 0; i--) begin
      if (info[i].st == S_ACTIVE
          && {1'b0, x} >= {1'b0, info[i].bx}
          && {1'b0, x} <  {1'b0, info[i].bx} + 11'(TILE)
          && {1'b0, y} >= {1'b0, info[i].by}
          && {1'b0, y} <  {1'b0, info[i].by} + 11'(TILE)) begin
        pix_hit  = 1'b1;
        pix_dx   = 4'(x - info[i].bx);
        pix_dy   = 4'(y - info[i].by);
        pix_addr = {7'(pix_dy) + kind_rowoff(info[i].kind), pix_dx};
      end
    end
  end

  ROM_Bubble_wrapper u_rom (
    .clk  (clk),
    .addr (pix_addr),
    .data (rom_q)
  );

  always_ff @(posedge clk) begin
    if (reset) vis_q <= 1'b0;
    else       vis_q <= pix_hit;
  end

  always_comb begin
    bubble_on = vis_q && (rom_q != KEY_COLOUR);
    rgb_out   = bubble_on ? rom_q : 12'h000;
  end

endmodule

// File: tb/tb_item_bubble_array.sv
// Directed bench for item_bubble_array with a per-cycle behavioural model
// of slots, placement LFSR, score and pixel output.
module tb_item_bubble_array;

  localparam int NB   = 3;
  localparam int RF   = 3;
  localparam int SMAX = 95;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int PY [7] = '{116, 116, 199, 282, 282, 365, 448};
  localparam int XM [7] = '{16, 480, 80, 16, 384, 112, 16};
  localparam int XK [7] = '{127, 127, 255, 127, 127, 255, 511};

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [9:0]  jojo_x;
  logic [9:0]  jojo_y;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        bubble_on;
  logic [11:0] rgb_out;
  logic [13:0] score;
  logic        new_score;
  logic [7:0]  points;

  item_bubble_array #(
    .NUM_BUBBLES    (NB),
    .RESPAWN_FRAMES (RF),
    .SCORE_MAX      (SMAX),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .jojo_x     (jojo_x),
    .jojo_y     (jojo_y),
    .x          (x),
    .y          (y),
    .bubble_on  (bubble_on),
    .rgb_out    (rgb_out),
    .score      (score),
    .new_score  (new_score),
    .points     (points)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // model state: st 0=active 1=hidden 2=spawn
  int m_st [NB];
  int m_bx [NB];
  int m_by [NB];
  int m_kind [NB];
  int m_plat [NB];
  int m_cnt [NB];
  int m_lfsr;
  int m_score;
  int m_pts;
  int m_new;
  int m_on;
  int m_rgb;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int k_pts(input int k);
    if (k < 30) return 10;
    if (k < 45) return 20;
    if (k < 55) return 30;
    if (k < 63) return 100;
    return 200;
  endfunction

  function automatic int k_row(input int k);
    if (k < 30) return 0;
    if (k < 45) return 16;
    if (k < 55) return 32;
    if (k < 63) return 48;
    return 64;
  endfunction

  // disc of radius ~7 centred in each 16x16 tile, yellow key outside
  function automatic int texel(input int row, input int col);
    int r;
    int dx;
    int dy;
    r  = row % 16;
    dx = 2 * col - 15;
    dy = 2 * r - 15;
    if (dx * dx + dy * dy < 200)
      return ((row / 16 + 1) << 8) | (r << 4) | col;
    return 'hFF0;
  endfunction

  task automatic model_step();
    int g;
    int s;
    int p;
    int fb;
    int c;
    int px;
    int py;
    int jx;
    int jy;
    bit blk;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_st[i]   = 0;
        m_plat[i] = i;
        m_bx[i]   = XM[i];
        m_by[i]   = PY[i];
        m_kind[i] = 0;
        m_cnt[i]  = 0;
      end
      m_lfsr  = SEED;
      m_score = 0;
      m_pts   = 0;
      m_new   = 0;
      m_on    = 0;
      m_rgb   = 0;
      return;
    end
    px = x;
    py = y;
    jx = jojo_x;
    jy = jojo_y;
    m_on  = 0;
    m_rgb = 0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (m_st[i] == 0 && px >= m_bx[i] && px < m_bx[i] + 16
          && py >= m_by[i] && py < m_by[i] + 16) begin
        c     = texel(k_row(m_kind[i]) + py - m_by[i], px - m_bx[i]);
        m_on  = (c != 'hFF0);
        m_rgb = m_on ? c : 0;
      end
    end
    g = -1;
    s = -1;
    for (int i = 0; i < NB; i++) begin
      if (g < 0 && m_st[i] == 0 && m_bx[i] + 17 > jx && m_bx[i] < jx + 25
          && m_by[i] + 13 > jy && m_by[i] < jy + 60)
        g = i;
      if (s < 0 && m_st[i] == 2) s = i;
    end
    p = m_lfsr & 7;
    if (p == 7) p = 0;
    blk = 1'b0;
    for (int i = 0; i < NB; i++)
      if (m_st[i] == 0 && m_plat[i] == p) blk = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (m_st[i] == 1 && frame_tick) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_st[i] = 2;
      end
    end
    if (g >= 0) begin
      m_st[g]  = 1;
      m_cnt[g] = RF;
      m_pts    = k_pts(m_kind[g]);
      m_score  = (m_score + m_pts > SMAX) ? SMAX : m_score + m_pts;
      m_new    = 1;
    end else begin
      m_new = 0;
    end
    if (s >= 0 && !blk) begin
      m_st[s]   = 0;
      m_plat[s] = p;
      m_by[s]   = PY[p];
      m_bx[s]   = (XM[p] + ((m_lfsr & 1023) & XK[p])) & ~1;
      m_kind[s] = (m_lfsr >> 10) & 63;
    end
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("new_score", int'(new_score), m_new);
      chk("points", int'(points), m_pts);
      chk("score", int'(score), m_score);
      chk("bubble_on", int'(bubble_on), m_on);
      chk("rgb_out", int'(rgb_out), m_rgb);
    end
  end

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic probe();
    int j;
    int col;
    int row;
    j   = cyc % NB;
    col = (cyc / NB) % 18 - 1;
    row = (cyc / 7) % 16;
    x   = 10'(m_bx[j] + col);
    y   = 10'(m_by[j] + row);
  endtask

  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) begin
      frame_tick = (per > 0) && (cyc % per == 0);
      probe();
      tick_cycle();
    end
  endtask

  task automatic collect_first_active();
    int j;
    j = -1;
    for (int t = 0; t < 5 && j < 0; t++) begin
      for (int i = NB - 1; i >= 0; i--)
        if (m_st[i] == 0) j = i;
      if (j < 0) run(10, 2);
    end
    if (j < 0) begin
      chk("active_slot_available", 0, 1);
      return;
    end
    frame_tick = 1'b0;
    jojo_x = 10'(m_bx[j]);
    jojo_y = 10'(m_by[j] - 10);
    probe();
    tick_cycle();
    chk("collect_pulse", int'(new_score), 1);
    jojo_x = '0;
    jojo_y = '0;
  endtask

  int ns_seen;

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b1;
    jojo_x     = '0;
    jojo_y     = '0;
    x          = '0;
    y          = '0;
    tick_cycle();
    chk_en = 1'b1;
    tick_cycle();
    tick_cycle();
    reset = 1'b0;
    chk("rst_score", int'(score), 0);
    chk("rst_new_score", int'(new_score), 0);
    chk("rst_points", int'(points), 0);
    chk("rst_bubble_on", int'(bubble_on), 0);
    chk("rst_rgb", int'(rgb_out), 0);

    // JOJO far away: no collections at all
    ns_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      frame_tick = (cyc % 5 == 0);
      probe();
      tick_cycle();
      if (new_score) ns_seen++;
    end
    chk("far_no_pulse", ns_seen, 0);
    chk("far_score", int'(score), 0);

    // slot 0 at (16,116): centre opaque, corner transparent, 1-cycle latency
    frame_tick = 1'b0;
    x = 10'd16;
    y = 10'd116;
    tick_cycle();
    chk("corner_off", int'(bubble_on), 0);
    x = 10'd23;
    y = 10'd123;
    chk("latency_still_off", int'(bubble_on), 0);
    tick_cycle();
    chk("centre_on", int'(bubble_on), 1);
    chk("centre_rgb", int'(rgb_out), 'h177);
    x = 10'd16;
    y = 10'd116;
    chk("latency_still_on", int'(bubble_on), 1);
    tick_cycle();
    chk("corner_off2", int'(bubble_on), 0);
    chk("corner_rgb", int'(rgb_out), 0);

    // first collection of slot 0
    jojo_x = 10'd16;
    jojo_y = 10'd100;
    tick_cycle();
    chk("hit_pulse", int'(new_score), 1);
    chk("hit_points", int'(points), 10);
    chk("hit_score", int'(score), 10);
    jojo_x = '0;
    jojo_y = '0;
    x = 10'd23;
    y = 10'd123;
    tick_cycle();
    chk("pulse_one_cycle", int'(new_score), 0);
    tick_cycle();
    chk("hidden_not_drawn", int'(bubble_on), 0);
    run(40, 4);

    // paired collections force simultaneous respawns; score saturates
    for (int it = 0; it < 8; it++) begin
      collect_first_active();
      collect_first_active();
      run(30, 3);
    end
    chk("sat_score", int'(score), SMAX);

    // reset while a slot is hidden restores the reset layout
    collect_first_active();
    run(4, 2);
    reset      = 1'b1;
    frame_tick = 1'b1;
    tick_cycle();
    tick_cycle();
    reset      = 1'b0;
    frame_tick = 1'b0;
    x = 10'd23;
    y = 10'd123;
    tick_cycle();
    chk("rst2_on", int'(bubble_on), 1);
    chk("rst2_rgb", int'(rgb_out), 'h177);
    chk("rst2_score", int'(score), 0);
    run(100, 5);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
